traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- done_pulse  in  1  one-cycle period-end strobe from the interval timer.
- ew_sensor  in  1  side-road vehicle presence, level.
- ped_req  in  1  pedestrian button, pulse or level.
- night_mode  in  1  flashing-mode request, level.
- timer_select  out  1  interval select to the timer: 1 = long, 0 = short.
- ns_light  out  3  main-road lamps {R,Y,G}.
- ew_light  out  3  side-road lamps {R,Y,G}.
- walk  out  1  pedestrian walk lamp.
- state_dbg  out  3  current state encoding.
REQ-002 SHALL have no parameters; interval lengths belong to the timer.

Function
REQ-003 SHALL implement an 8-state Moore FSM: NS_GREEN, NS_YELLOW, ALLRED_A, PED_WALK, EW_GREEN, EW_YELLOW, ALLRED_B, FLASH.
REQ-004 SHALL register all outputs as a function of state (and flash_phase only); outputs change on the clk edge after done_pulse is sampled high.
REQ-005 SHALL ignore done_pulse except as the transition strobe; no transition without done_pulse=1.
REQ-006 SHALL drive timer_select=1 in NS_GREEN, EW_GREEN and PED_WALK, and 0 in every other state.
REQ-007 SHALL use lamps per state (ns/ew/walk):
- NS_GREEN 001/100/0
- NS_YELLOW 010/100/0
- ALLRED_A, ALLRED_B 100/100/0
- PED_WALK 100/100/1
- EW_GREEN 100/001/0
- EW_YELLOW 100/010/0
- FLASH 010/100/0 when flash_phase=0, and 000/000/0 when flash_phase=1
REQ-008 SHALL hold request latches ew_pend and ped_pend:
- ew_pend set on ew_sensor=1 in any state except EW_GREEN and FLASH.
- ped_pend set on ped_req=1 in any state except PED_WALK and FLASH.
REQ-009 SHALL clear ew_pend on the edge entering EW_GREEN and ped_pend on the edge entering PED_WALK; clear wins over a simultaneous set.
REQ-010 SHALL hold both latches cleared while in FLASH.
REQ-011 SHALL transition on done_pulse=1 as follows:
- NS_GREEN: to NS_YELLOW if ew_pend, ped_pend or night_mode; otherwise stay (green extended by one long period).
- NS_YELLOW: to ALLRED_A.
- ALLRED_A: priority night_mode -> FLASH, then ped_pend -> PED_WALK, then ew_pend -> EW_GREEN, else NS_GREEN.
- PED_WALK: to EW_GREEN if ew_pend, else NS_GREEN.
- EW_GREEN: to EW_YELLOW; exactly one long period.
- EW_YELLOW: to ALLRED_B.
- ALLRED_B: to FLASH if night_mode, else NS_GREEN.
- FLASH: toggle flash_phase; if night_mode=0, to ALLRED_B with flash_phase cleared.
REQ-012 SHALL never show a non-red, non-off lamp on both roads simultaneously; walk=1 only in PED_WALK.
REQ-013 SHALL finish the current EW phase before honouring night_mode raised during EW_GREEN or EW_YELLOW.
REQ-014 SHALL output state_dbg encodings 0..7 in the REQ-003 order.

Reset
REQ-015 SHALL asynchronously force, while rst=0:
- state NS_GREEN, timer_select=1, ns_light=001, ew_light=100, walk=0
- ew_pend=0, ped_pend=0, flash_phase=0, state_dbg=0
REQ-016 SHALL resume from NS_GREEN on the first clk edge after rst rises; reset mid-phase discards all pending requests.

Structure
REQ-017 SHALL take state encodings and lamp constants (RED=100, YEL=010, GRN=001, OFF=000) from shared package traffic_pkg.
REQ-018 SHALL be a single module with no sub-module; the interval timer is instantiated beside it at system level, not inside it.

Verification
REQ-019 SHALL cover the following directed scenarios; the bench uses the team timer (long done every 11 cycles, short every 4):
- No requests, 60 cycles -> stays NS_GREEN, ns=001, ew=100, timer_select=1 throughout.
- ew_sensor 1-cycle pulse during NS_GREEN -> sequence NS_YELLOW(4 cycles), ALLRED_A(4), EW_GREEN(11), EW_YELLOW(4), ALLRED_B(4), NS_GREEN; ew_pend=0 from EW_GREEN onward.
- ped_req and ew_sensor both pulsed in NS_GREEN -> ALLRED_A then PED_WALK with walk=1 for 11 cycles, then EW_GREEN.
- ew_sensor high only while in EW_GREEN -> no second EW phase; returns to NS_GREEN and stays.
- night_mode=1 raised in EW_GREEN -> EW_YELLOW, ALLRED_B, FLASH with ns alternating 010/000 every 4 cycles; deassert -> ALLRED_B -> NS_GREEN.
- rst=0 mid EW_YELLOW -> outputs at reset values before the next clk edge; after release, NS_GREEN with no pending service.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encodings and lamp constants for the traffic light controller
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALLRED_A  = 3'd2,
      PED_WALK  = 3'd3,
      EW_GREEN  = 3'd4,
      EW_YELLOW = 3'd5,
      ALLRED_B  = 3'd6,
      FLASH     = 3'd7
   } state_t;

   // Lamp triplets are {R,Y,G}
   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - Moore traffic light FSM with request latches and night flash mode
module traffic_light_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       done_pulse,
   input  logic       ew_sensor,
   input  logic       ped_req,
   input  logic       night_mode,
   output logic       timer_select,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic [2:0] state_dbg
);
   import traffic_pkg::*;

   state_t     state;
   state_t     next_state;
   logic       flash_phase;
   logic       next_phase;
   logic       ew_pend;
   logic       ped_pend;
   logic       ew_pend_next;
   logic       ped_pend_next;
   logic [2:0] ns_next;
   logic [2:0] ew_next;
   logic       walk_next;
   logic       tsel_next;

   always_comb begin
      next_state = state;
      next_phase = flash_phase;
      if (done_pulse) begin
         case (state)
            NS_GREEN:  next_state = (ew_pend || ped_pend || night_mode) ? NS_YELLOW : NS_GREEN;
            NS_YELLOW: next_state = ALLRED_A;
            ALLRED_A: begin
               if (night_mode)    next_state = FLASH;
               else if (ped_pend) next_state = PED_WALK;
               else if (ew_pend)  next_state = EW_GREEN;
               else               next_state = NS_GREEN;
            end
            PED_WALK:  next_state = ew_pend ? EW_GREEN : NS_GREEN;
            EW_GREEN:  next_state = EW_YELLOW;
            EW_YELLOW: next_state = ALLRED_B;
            ALLRED_B:  next_state = night_mode ? FLASH : NS_GREEN;
            FLASH: begin
               if (night_mode) begin
                  next_phase = ~flash_phase;
               end else begin
                  next_state = ALLRED_B;
                  next_phase = 1'b0;
               end
            end
            default:   next_state = NS_GREEN;
         endcase
      end
   end

   // Clearing on entry beats a same-cycle set; both latches stay empty throughout FLASH.
   always_comb begin
      ew_pend_next  = (ew_pend || (ew_sensor && state != EW_GREEN && state != FLASH))
                      && next_state != EW_GREEN && next_state != FLASH;
      ped_pend_next = (ped_pend || (ped_req && state != PED_WALK && state != FLASH))
                      && next_state != PED_WALK && next_state != FLASH;
   end

   always_comb begin
      ns_next   = RED;
      ew_next   = RED;
      walk_next = 1'b0;
      tsel_next = 1'b0;
      case (next_state)
         NS_GREEN: begin
            ns_next   = GRN;
            tsel_next = 1'b1;
         end
         NS_YELLOW: ns_next = YEL;
         PED_WALK: begin
            walk_next = 1'b1;
            tsel_next = 1'b1;
         end
         EW_GREEN: begin
            ew_next   = GRN;
            tsel_next = 1'b1;
         end
         EW_YELLOW: ew_next = YEL;
         FLASH: begin
            ns_next = next_phase ? OFF : YEL;
            ew_next = next_phase ? OFF : RED;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= NS_GREEN;
         flash_phase  <= 1'b0;
         ew_pend      <= 1'b0;
         ped_pend     <= 1'b0;
         timer_select <= 1'b1;
         ns_light     <= GRN;
         ew_light     <= RED;
         walk         <= 1'b0;
         state_dbg    <= 3'd0;
      end else begin
         state        <= next_state;
         flash_phase  <= next_phase;
         ew_pend      <= ew_pend_next;
         ped_pend     <= ped_pend_next;
         timer_select <= tsel_next;
         ns_light     <= ns_next;
         ew_light     <= ew_next;
         walk         <= walk_next;
         state_dbg    <= next_state;
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - self-checking bench: vector table, timer-driven scenarios, random vs reference model
module tb_traffic_light_ctrl;

   localparam int S_NSG = 0, S_NSY = 1, S_ARA = 2, S_PW = 3;
   localparam int S_EWG = 4, S_EWY = 5, S_ARB = 6, S_FL = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       done_pulse = 1'b0;
   logic       ew_sensor = 1'b0;
   logic       ped_req = 1'b0;
   logic       night_mode = 1'b0;
   logic       timer_select;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk;
   logic [2:0] state_dbg;

   traffic_light_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .done_pulse   (done_pulse),
      .ew_sensor    (ew_sensor),
      .ped_req      (ped_req),
      .night_mode   (night_mode),
      .timer_select (timer_select),
      .ns_light     (ns_light),
      .ew_light     (ew_light),
      .walk         (walk),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       ew, ped, night, done;
      int       st;
      bit [2:0] ns, ewl;
      bit       wk, ts;
   } vec_t;

   int total = 0;
   int bad = 0;
   int m_state = S_NSG;
   int m_phase = 0;
   bit m_ew = 0, m_ped = 0;
   int tcnt = 0;
   bit use_timer = 0;
   int rs[$];
   int rl[$];

   function automatic vec_t mk(bit e, bit p, bit n, bit d, int s, bit [2:0] ns, bit [2:0] ew, bit wk, bit ts);
      vec_t v;
      v.ew = e; v.ped = p; v.night = n; v.done = d; v.st = s;
      v.ns = ns; v.ewl = ew; v.wk = wk; v.ts = ts;
      return v;
   endfunction

   function automatic int exp_ns(int s, int ph);
      if (s == S_NSG) return 3'b001;
      if (s == S_NSY) return 3'b010;
      if (s == S_FL)  return ph ? 3'b000 : 3'b010;
      return 3'b100;
   endfunction

   function automatic int exp_ew(int s, int ph);
      if (s == S_EWG) return 3'b001;
      if (s == S_EWY) return 3'b010;
      if (s == S_FL)  return ph ? 3'b000 : 3'b100;
      return 3'b100;
   endfunction

   function automatic bit exp_tsel(int s);
      return (s == S_NSG) || (s == S_PW) || (s == S_EWG);
   endfunction

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      bit ns_go, ew_go;
      chk("state", int'(state_dbg), m_state);
      chk("ns_light", int'(ns_light), exp_ns(m_state, m_phase));
      chk("ew_light", int'(ew_light), exp_ew(m_state, m_phase));
      chk("walk", int'(walk), int'(m_state == S_PW));
      chk("timer_select", int'(timer_select), int'(exp_tsel(m_state)));
      ns_go = (ns_light != 3'b100) && (ns_light != 3'b000);
      ew_go = (ew_light != 3'b100) && (ew_light != 3'b000);
      chk("conflict", int'(ns_go && ew_go), 0);
   endtask

   task automatic model_step();
      int nxt = m_state;
      int nph = m_phase;
      bit ew_set, ped_set;
      if (done_pulse) begin
         if (m_state == S_NSG)      nxt = (m_ew || m_ped || night_mode) ? S_NSY : S_NSG;
         else if (m_state == S_NSY) nxt = S_ARA;
         else if (m_state == S_ARA) nxt = night_mode ? S_FL : (m_ped ? S_PW : (m_ew ? S_EWG : S_NSG));
         else if (m_state == S_PW)  nxt = m_ew ? S_EWG : S_NSG;
         else if (m_state == S_EWG) nxt = S_EWY;
         else if (m_state == S_EWY) nxt = S_ARB;
         else if (m_state == S_ARB) nxt = night_mode ? S_FL : S_NSG;
         else if (night_mode)       nph = 1 - m_phase;
         else begin
            nxt = S_ARB;
            nph = 0;
         end
      end
      ew_set  = ew_sensor && m_state != S_EWG && m_state != S_FL;
      ped_set = ped_req && m_state != S_PW && m_state != S_FL;
      m_ew    = (m_ew || ew_set) && nxt != S_EWG && nxt != S_FL;
      m_ped   = (m_ped || ped_set) && nxt != S_PW && nxt != S_FL;
      m_state = nxt;
      m_phase = nph;
      tcnt    = done_pulse ? 0 : tcnt + 1;
   endtask

   task automatic tick();
      if (use_timer) done_pulse = (tcnt == (exp_tsel(m_state) ? 10 : 3));
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic wait_state(int target, int budget, string nm);
      int n = 0;
      while (m_state != target && n < budget) begin
         tick();
         n++;
      end
      if (m_state != target) chk({nm, "_timeout"}, m_state, target);
   endtask

   task automatic record_run(int budget);
      int prev = -1;
      bit left = 0;
      int n = 0;
      rs.delete();
      rl.delete();
      while (n < budget) begin
         tick();
         n++;
         if (state_dbg == 3'd0 && left) break;
         if (state_dbg != 3'd0) begin
            left = 1;
            if (int'(state_dbg) == prev) rl[rl.size()-1]++;
            else begin
               rs.push_back(int'(state_dbg));
               rl.push_back(1);
            end
            prev = int'(state_dbg);
         end
      end
      if (n >= budget) chk("record_timeout", n, 0);
   endtask

   task automatic pulse_ew();
      ew_sensor = 1'b1;
      tick();
      ew_sensor = 1'b0;
   endtask

   vec_t vt[24];

   initial begin
      int exp_s[$];
      int exp_l[$];
      int cnt;

      vt[0]  = mk(0,0,0,0, S_NSG, 3'b001, 3'b100, 0, 1);
      vt[1]  = mk(1,0,0,0, S_NSG, 3'b001, 3'b100, 0, 1);
      vt[2]  = mk(0,0,0,1, S_NSY, 3'b010, 3'b100, 0, 0);
      vt[3]  = mk(0,0,0,1, S_ARA, 3'b100, 3'b100, 0, 0);
      vt[4]  = mk(0,0,0,1, S_EWG, 3'b100, 3'b001, 0, 1);
      vt[5]  = mk(1,0,0,0, S_EWG, 3'b100, 3'b001, 0, 1);
      vt[6]  = mk(1,0,0,1, S_EWY, 3'b100, 3'b010, 0, 0);
      vt[7]  = mk(0,0,0,1, S_ARB, 3'b100, 3'b100, 0, 0);
      vt[8]  = mk(0,0,0,1, S_NSG, 3'b001, 3'b100, 0, 1);
      vt[9]  = mk(0,1,0,1, S_NSG, 3'b001, 3'b100, 0, 1);
      vt[10] = mk(0,0,0,1, S_NSY, 3'b010, 3'b100, 0, 0);
      vt[11] = mk(0,0,0,1, S_ARA, 3'b100, 3'b100, 0, 0);
      vt[12] = mk(0,0,1,0, S_ARA, 3'b100, 3'b100, 0, 0);
      vt[13] = mk(0,0,0,1, S_PW,  3'b100, 3'b100, 1, 1);
      vt[14] = mk(0,0,0,1, S_NSG, 3'b001, 3'b100, 0, 1);
      vt[15] = mk(0,0,1,1, S_NSY, 3'b010, 3'b100, 0, 0);
      vt[16] = mk(0,0,1,1, S_ARA, 3'b100, 3'b100, 0, 0);
      vt[17] = mk(0,0,1,1, S_FL,  3'b010, 3'b100, 0, 0);
      vt[18] = mk(0,0,1,1, S_FL,  3'b000, 3'b000, 0, 0);
      vt[19] = mk(1,1,1,0, S_FL,  3'b000, 3'b000, 0, 0);
      vt[20] = mk(0,0,1,1, S_FL,  3'b010, 3'b100, 0, 0);
      vt[21] = mk(1,1,0,1, S_ARB, 3'b100, 3'b100, 0, 0);
      vt[22] = mk(0,0,0,1, S_NSG, 3'b001, 3'b100, 0, 1);
      vt[23] = mk(0,0,0,1, S_NSG, 3'b001, 3'b100, 0, 1);

      #1 rst = 1'b0;
      #1;
      chk("rst_state", int'(state_dbg), 0);
      chk("rst_ns", int'(ns_light), 3'b001);
      chk("rst_ew", int'(ew_light), 3'b100);
      chk("rst_walk", int'(walk), 0);
      chk("rst_tsel", int'(timer_select), 1);
      #10 rst = 1'b1;

      // Vector table: done strobes supplied directly
      use_timer = 0;
      for (int i = 0; i < 24; i++) begin
         ew_sensor = vt[i].ew; ped_req = vt[i].ped;
         night_mode = vt[i].night; done_pulse = vt[i].done;
         tick();
         chk($sformatf("vec%0d_state", i), int'(state_dbg), vt[i].st);
         chk($sformatf("vec%0d_ns", i), int'(ns_light), int'(vt[i].ns));
         chk($sformatf("vec%0d_ew", i), int'(ew_light), int'(vt[i].ewl));
         chk($sformatf("vec%0d_walk", i), int'(walk), int'(vt[i].wk));
         chk($sformatf("vec%0d_tsel", i), int'(timer_select), int'(vt[i].ts));
      end
      ew_sensor = 0; ped_req = 0; night_mode = 0; done_pulse = 0;

      // Timer-driven scenarios: long period 11 cycles, short 4
      use_timer = 1;
      tcnt = 0;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (state_dbg != 3'd0) cnt++;
      end
      chk("idle_not_nsg_cycles", cnt, 0);

      pulse_ew();
      record_run(200);
      exp_s = '{S_NSY, S_ARA, S_EWG, S_EWY, S_ARB};
      exp_l = '{4, 4, 11, 4, 4};
      chk("ew_seq_len", rs.size(), exp_s.size());
      for (int i = 0; i < exp_s.size() && i < rs.size(); i++) begin
         chk($sformatf("ew_seq%0d_state", i), rs[i], exp_s[i]);
         chk($sformatf("ew_seq%0d_cycles", i), rl[i], exp_l[i]);
      end

      ped_req = 1; ew_sensor = 1;
      tick();
      ped_req = 0; ew_sensor = 0;
      record_run(200);
      exp_s = '{S_NSY, S_ARA, S_PW, S_EWG, S_EWY, S_ARB};
      exp_l = '{4, 4, 11, 11, 4, 4};
      chk("ped_seq_len", rs.size(), exp_s.size());
      for (int i = 0; i < exp_s.size() && i < rs.size(); i++) begin
         chk($sformatf("ped_seq%0d_state", i), rs[i], exp_s[i]);
         chk($sformatf("ped_seq%0d_cycles", i), rl[i], exp_l[i]);
      end

      pulse_ew();
      wait_state(S_EWG, 100, "sc4_ewg");
      for (int n = 0; n < 100 && m_state != S_NSG; n++) begin
         ew_sensor = (m_state == S_EWG);
         tick();
      end
      ew_sensor = 0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (state_dbg != 3'd0) cnt++;
      end
      chk("ew_in_ewg_no_repeat", cnt, 0);

      pulse_ew();
      wait_state(S_EWG, 100, "sc5_ewg");
      night_mode = 1;
      tick();
      chk("night_finishes_ew", int'(state_dbg), S_EWG);
      wait_state(S_FL, 100, "sc5_flash");
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("flash_ns%0d", i), int'(ns_light), ((i / 4) % 2) ? 3'b000 : 3'b010);
         tick();
      end
      night_mode = 0;
      wait_state(S_ARB, 20, "sc5_arb");
      wait_state(S_NSG, 20, "sc5_nsg");

      pulse_ew();
      wait_state(S_EWY, 100, "sc6_ewy");
      ped_req = 1;
      tick();
      ped_req = 0;
      #3 rst = 1'b0;
      #1;
      chk("midrst_state", int'(state_dbg), 0);
      chk("midrst_ns", int'(ns_light), 3'b001);
      chk("midrst_ew", int'(ew_light), 3'b100);
      chk("midrst_tsel", int'(timer_select), 1);
      m_state = S_NSG; m_phase = 0; m_ew = 0; m_ped = 0; tcnt = 0;
      #2 rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (state_dbg != 3'd0) cnt++;
      end
      chk("post_rst_no_service", cnt, 0);

      // Random stimulus against the reference model
      use_timer = 0;
      for (int i = 0; i < 1500; i++) begin
         done_pulse = ($urandom_range(0, 2) == 0);
         ew_sensor  = ($urandom_range(0, 7) == 0);
         ped_req    = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 39) == 0) night_mode = ~night_mode;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
